sb_scratch_ram: RTL and testbench

Word-addressed scratch memory that is a slave on the shared system bus. It answers single and burst read/write transactions issued by the JTAG debug interface, or by any other bus master, once the bus arbiter has granted that master. It is the downstream target of debug memory accesses and replaces the emulated SDRAM slave in block-level and system benches. All of its outputs are driven to zero when it is not responding, so they can be ORed directly onto the shared bus.

---
 rtl/sb_scratch_ram.sv | 213 +++++++++++++++++++++
 tb/tb_sb_scratch_ram.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_scratch_ram.sv
// sb_scratch_ram
// Word-addressed scratch memory acting as a slave on the shared system bus.
// It answers single and burst reads/writes. Every output is zero while the
// block is not actively responding, so outputs can be ORed onto the bus.
//
// Ports:
//   sb_clock_i             bus clock, rising edge
//   sb_reset_n_i           asynchronous active-low reset
//   sb_begin_transaction_i one-cycle request strobe (address/attributes valid)
//   sb_end_transaction_i   master/arbiter terminates the current transaction
//   sb_error_i             bus-wide error; aborts an active transaction
//   sb_address_data_i      byte address in the begin cycle, write data on beats
//   sb_byte_enables_i      write byte lanes, captured in the begin cycle
//   sb_burst_size_i        beats minus one
//   sb_read_n_write_i      1 = read, 0 = write
//   sb_data_valid_i        write data beat valid
//   sb_address_data_o      read data, zero when sb_data_valid_o is low
//   sb_data_valid_o        read beat valid
//   sb_end_transaction_o   slave ends a read burst
//   sb_busy_o              write stall
//   sb_error_o             one-cycle error pulse
//   dbg_state_o            current FSM state (debug observation)
//
// Handshake: a request is taken only in IDLE on sb_begin_transaction_i.
// Read beats are presented on consecutive cycles with sb_data_valid_o high and
// cannot be stalled; write beats are accepted on every cycle in WR_DATA where
// sb_data_valid_i is high, up to burst_size+1 beats.
module sb_scratch_ram #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          ADDR_WIDTH     = 10,
  parameter int          READ_LATENCY   = 2,
  parameter int          WR_BUSY_CYCLES = 0
) (
  input  logic        sb_clock_i,
  input  logic        sb_reset_n_i,
  input  logic        sb_begin_transaction_i,
  input  logic        sb_end_transaction_i,
  input  logic        sb_error_i,
  input  logic [31:0] sb_address_data_i,
  input  logic [3:0]  sb_byte_enables_i,
  input  logic [7:0]  sb_burst_size_i,
  input  logic        sb_read_n_write_i,
  input  logic        sb_data_valid_i,
  output logic [31:0] sb_address_data_o,
  output logic        sb_data_valid_o,
  output logic        sb_end_transaction_o,
  output logic        sb_busy_o,
  output logic        sb_error_o,
  output logic [2:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SUM_W = ADDR_WIDTH + 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DATA = 3'd2,
    S_RD_END  = 3'd3,
    S_WR_BUSY = 3'd4,
    S_WR_DATA = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [8:0]            beats_q, beats_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  rd_en;
  logic                  wr_en;
  logic                  sel;
  logic                  misaligned;
  logic                  overrun;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [SUM_W-1:0]      last_idx;

  assign req_idx    = sb_address_data_i[ADDR_WIDTH+1:2];
  assign sel        = sb_begin_transaction_i &&
                      (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign misaligned = |sb_address_data_i[1:0];
  // Index of the final beat, computed wide so it cannot wrap.
  assign last_idx   = SUM_W'(req_idx) + SUM_W'(sb_burst_size_i);
  assign overrun    = last_idx > SUM_W'(DEPTH - 1);

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      beats_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    be_d    = be_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          if (misaligned || overrun) begin
            state_d = S_ERR;
          end else begin
            idx_d = req_idx;
            be_d  = sb_byte_enables_i;
            if (sb_read_n_write_i) begin
              state_d = S_RD_WAIT;
              cnt_d   = 4'(READ_LATENCY - 1);
              // For reads, beats_q counts beats still to follow the current one.
              beats_d = {1'b0, sb_burst_size_i};
            end else begin
              // For writes, beats_q counts beats still allowed to be written.
              beats_d = {1'b0, sb_burst_size_i} + 9'd1;
              if (WR_BUSY_CYCLES > 0) begin
                state_d = S_WR_BUSY;
                cnt_d   = 4'(WR_BUSY_CYCLES - 1);
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end
        end
      end

      S_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Fetch the first word one cycle ahead of its beat.
          rd_en   = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_RD_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RD_DATA: begin
        if (beats_q == 9'd0) begin
          state_d = S_RD_END;
        end else begin
          beats_d = beats_q - 9'd1;
          rd_en   = 1'b1;
          idx_d   = idx_q + 1'b1;
        end
      end

      S_RD_END: state_d = S_IDLE;

      S_WR_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WR_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WR_DATA: begin
        if (sb_data_valid_i && (beats_q != 9'd0)) begin
          wr_en   = 1'b1;
          idx_d   = idx_q + 1'b1;
          beats_d = beats_q - 9'd1;
        end
      end

      S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Termination from the bus wins over any local progress; a beat offered
    // in the same cycle as the end is still written.
    if ((state_q != S_IDLE) && (sb_end_transaction_i || sb_error_i)) begin
      state_d = S_IDLE;
    end
  end

  // RAM array: no reset so it maps onto block memory.
  always_ff @(posedge sb_clock_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= sb_address_data_i[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem_q[idx_q];
    end
  end

  assign sb_data_valid_o      = (state_q == S_RD_DATA);
  assign sb_address_data_o    = sb_data_valid_o ? rdata_q : 32'h0;
  assign sb_end_transaction_o = (state_q == S_RD_END);
  assign sb_busy_o            = (state_q == S_WR_BUSY);
  assign sb_error_o           = (state_q == S_ERR);
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_sb_scratch_ram.sv
// Bench for sb_scratch_ram: instance a uses the default write path (no busy),
// instance b uses five busy cycles. Read data is scored against a byte-lane
// memory model through expected queues.
module tb_sb_scratch_ram;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] model [1024];
  logic [31:0] wbuf [16];

  // Instance a signals
  logic        a_begin, a_end, a_err, a_rnw, a_dv;
  logic [31:0] a_ad;
  logic [3:0]  a_be;
  logic [7:0]  a_burst;
  logic [31:0] a_do;
  logic        a_dvo, a_endo, a_busy, a_erro;
  logic [2:0]  a_state;

  // Instance b signals
  logic        b_begin, b_end, b_err, b_rnw, b_dv;
  logic [31:0] b_ad;
  logic [3:0]  b_be;
  logic [7:0]  b_burst;
  logic [31:0] b_do;
  logic        b_dvo, b_endo, b_busy, b_erro;
  logic [2:0]  b_state;

  sb_scratch_ram #(.BASE_ADDR(32'h0000_1000), .ADDR_WIDTH(10), .READ_LATENCY(2),
                   .WR_BUSY_CYCLES(0)) dut_a (
    .sb_clock_i(clk), .sb_reset_n_i(rst_n),
    .sb_begin_transaction_i(a_begin), .sb_end_transaction_i(a_end), .sb_error_i(a_err),
    .sb_address_data_i(a_ad), .sb_byte_enables_i(a_be), .sb_burst_size_i(a_burst),
    .sb_read_n_write_i(a_rnw), .sb_data_valid_i(a_dv),
    .sb_address_data_o(a_do), .sb_data_valid_o(a_dvo), .sb_end_transaction_o(a_endo),
    .sb_busy_o(a_busy), .sb_error_o(a_erro), .dbg_state_o(a_state)
  );

  sb_scratch_ram #(.BASE_ADDR(32'h0000_1000), .ADDR_WIDTH(10), .READ_LATENCY(2),
                   .WR_BUSY_CYCLES(5)) dut_b (
    .sb_clock_i(clk), .sb_reset_n_i(rst_n),
    .sb_begin_transaction_i(b_begin), .sb_end_transaction_i(b_end), .sb_error_i(b_err),
    .sb_address_data_i(b_ad), .sb_byte_enables_i(b_be), .sb_burst_size_i(b_burst),
    .sb_read_n_write_i(b_rnw), .sb_data_valid_i(b_dv),
    .sb_address_data_o(b_do), .sb_data_valid_o(b_dvo), .sb_end_transaction_o(b_endo),
    .sb_busy_o(b_busy), .sb_error_o(b_erro), .dbg_state_o(b_state)
  );

  // Scoreboard monitors: pop on every read beat, otherwise data must be zero.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (a_dvo === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_beat: got %h expected no beat", a_do);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (a_do !== e) begin
            errors++;
            $display("FAIL a_rdata: got %h expected %h", a_do, e);
          end
        end
      end else if (a_do !== 32'h0) begin
        errors++;
        $display("FAIL a_idle_data: got %h expected 00000000", a_do);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (b_dvo === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_beat: got %h expected no beat", b_do);
        end else begin
          logic [31:0] e;
          e = exp_b_q.pop_front();
          if (b_do !== e) begin
            errors++;
            $display("FAIL b_rdata: got %h expected %h", b_do, e);
          end
        end
      end else if (b_do !== 32'h0) begin
        errors++;
        $display("FAIL b_idle_data: got %h expected 00000000", b_do);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int w, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [3:0] be,
                         input int burst, input int nbeats);
    int w;
    w = int'(addr[11:2]);
    a_ad = addr; a_be = be; a_burst = 8'(burst); a_rnw = 1'b0; a_begin = 1'b1;
    step();
    a_begin = 1'b0; a_burst = 8'd0;
    for (int i = 0; i < nbeats; i++) begin
      a_dv = 1'b1;
      a_ad = wbuf[i];
      if (i <= burst) model_write(w + i, be, wbuf[i]);
      step();
    end
    a_dv = 1'b0; a_ad = 32'h0; a_be = 4'h0; a_end = 1'b1;
    step();
    a_end = 1'b0;
    checks++;
    if (a_state !== 3'd0) begin
      errors++;
      $display("FAIL a_write_done_state: got %0d expected 0", a_state);
    end
  endtask

  task automatic a_read(input logic [31:0] addr, input int burst);
    int w;
    logic exp_dv, exp_end;
    w = int'(addr[11:2]);
    for (int i = 0; i <= burst; i++) exp_q.push_back(model[w + i]);
    a_ad = addr; a_burst = 8'(burst); a_rnw = 1'b1; a_begin = 1'b1;
    step();
    a_begin = 1'b0; a_ad = 32'h0; a_burst = 8'd0; a_rnw = 1'b0;
    for (int n = 1; n <= burst + 5; n++) begin
      exp_dv  = (n >= 3) && (n <= 3 + burst);
      exp_end = (n == 4 + burst);
      checks++;
      if (a_dvo !== exp_dv || a_endo !== exp_end || a_erro !== 1'b0) begin
        errors++;
        $display("FAIL a_read_timing n=%0d: got dv=%b end=%b err=%b expected dv=%b end=%b err=0",
                 n, a_dvo, a_endo, a_erro, exp_dv, exp_end);
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL a_read_beats_left: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic a_err_read(input logic [31:0] addr, input int burst);
    a_ad = addr; a_burst = 8'(burst); a_rnw = 1'b1; a_begin = 1'b1;
    step();
    a_begin = 1'b0; a_ad = 32'h0; a_burst = 8'd0; a_rnw = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      checks++;
      if (a_erro !== (n == 1) || a_dvo !== 1'b0 || a_endo !== 1'b0) begin
        errors++;
        $display("FAIL a_error_pulse addr=%h n=%0d: got err=%b dv=%b end=%b expected err=%b dv=0 end=0",
                 addr, n, a_erro, a_dvo, a_endo, (n == 1));
      end
      step();
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_do, a_dvo, a_endo, a_busy, a_erro, a_state} !== 41'h0) begin
      errors++;
      $display("FAIL reset_outputs: got do=%h dv=%b end=%b busy=%b err=%b st=%0d expected all 0",
               a_do, a_dvo, a_endo, a_busy, a_erro, a_state);
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (a_state !== 3'd0 || b_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%0d b=%0d expected 0 0", a_state, b_state);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEAD_BEEF;
    a_write(32'h0000_1000, 4'hF, 0, 1);
    a_read(32'h0000_1000, 0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    a_write(32'h0000_1010, 4'hF, 3, 4);
    a_read(32'h0000_1010, 3);
  endtask

  task automatic test_byte_enables();
    wbuf[0] = 32'hFFFF_FFFF;
    a_write(32'h0000_1020, 4'hF, 0, 1);
    wbuf[0] = 32'h1122_3344;
    a_write(32'h0000_1020, 4'b0101, 0, 1);
    a_read(32'h0000_1020, 0);
  endtask

  task automatic test_drop_extra_beats();
    wbuf[0] = 32'h5555_AAAA;
    a_write(32'h0000_1048, 4'hF, 0, 1);
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom_range(32'h7FFF_FFFF, 0) | 32'h8000_0000;
    // burst_size 1: third beat aimed at 0x1048 must be dropped
    a_write(32'h0000_1040, 4'hF, 1, 3);
    a_read(32'h0000_1040, 2);
  endtask

  task automatic test_errors();
    a_err_read(32'h0000_1002, 0);
    a_err_read(32'h0000_1FFC, 1);
  endtask

  task automatic test_outside();
    a_ad = 32'h0000_3000; a_burst = 8'd0; a_rnw = 1'b1; a_begin = 1'b1;
    step();
    a_begin = 1'b0; a_ad = 32'h0; a_rnw = 1'b0;
    for (int n = 0; n < 20; n++) begin
      checks++;
      if ({a_do, a_dvo, a_endo, a_busy, a_erro, a_state} !== 41'h0) begin
        errors++;
        $display("FAIL outside_window n=%0d: got do=%h dv=%b end=%b busy=%b err=%b st=%0d expected all 0",
                 n, a_do, a_dvo, a_endo, a_busy, a_erro, a_state);
      end
      step();
    end
  endtask

  task automatic test_busy();
    b_ad = 32'h0000_1030; b_be = 4'hF; b_burst = 8'd0; b_rnw = 1'b0; b_begin = 1'b1;
    step();
    b_begin = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      b_dv = 1'b1;
      b_ad = 32'hA000_0000 + 32'(n);
      checks++;
      if (b_busy !== (n <= 5)) begin
        errors++;
        $display("FAIL b_busy n=%0d: got %b expected %b", n, b_busy, (n <= 5));
      end
      step();
    end
    b_dv = 1'b0; b_ad = 32'h0; b_be = 4'h0; b_end = 1'b1;
    step();
    b_end = 1'b0;
    // Only the beat presented in the first cycle after busy is written.
    exp_b_q.push_back(32'hA000_0006);
    b_ad = 32'h0000_1030; b_rnw = 1'b1; b_begin = 1'b1;
    step();
    b_begin = 1'b0; b_ad = 32'h0; b_rnw = 1'b0;
    repeat (6) step();
    checks++;
    if (exp_b_q.size() != 0 || b_state !== 3'd0) begin
      errors++;
      $display("FAIL b_readback: got pending=%0d st=%0d expected 0 0", exp_b_q.size(), b_state);
      exp_b_q.delete();
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 4; i++) exp_q.push_back(model[4 + i]);
    a_ad = 32'h0000_1010; a_burst = 8'd3; a_rnw = 1'b1; a_begin = 1'b1;
    step();
    a_begin = 1'b0; a_ad = 32'h0; a_burst = 8'd0; a_rnw = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_do, a_dvo, a_endo, a_busy, a_erro, a_state} !== 41'h0) begin
      errors++;
      $display("FAIL reset_mid_read_outputs: got do=%h dv=%b end=%b st=%0d expected all 0",
               a_do, a_dvo, a_endo, a_state);
    end
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL reset_mid_read_beats: got %0d pending expected 2", exp_q.size());
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    a_read(32'h0000_1000, 0);
  endtask

  initial begin
    a_begin = 0; a_end = 0; a_err = 0; a_rnw = 0; a_dv = 0; a_ad = 0; a_be = 0; a_burst = 0;
    b_begin = 0; b_end = 0; b_err = 0; b_rnw = 0; b_dv = 0; b_ad = 0; b_be = 0; b_burst = 0;
    test_reset();
    test_single();
    test_burst();
    test_byte_enables();
    test_drop_extra_beats();
    test_errors();
    test_outside();
    test_busy();
    test_reset_mid_read();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
